// File: rtl/recovery_ctrl_pkg.sv
// Shared types and constants for the pipeline recovery controller.
//   rec_state_t : recovery FSM states
//   rec_cause_t : redirect cause, in priority order EXCP > ERTN > BR > IDLE
//   PC_STEP     : sequential instruction stride
package recovery_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        RESTORE   = 2'd2,
        IDLE_WAIT = 2'd3
    } rec_state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_EXCP = 3'd1,
        C_ERTN = 3'd2,
        C_BR   = 3'd3,
        C_IDLE = 3'd4
    } rec_cause_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/recovery_ctrl_pc_sel.sv
// Combinational cause priority and redirect-PC mux for the committing ROB head.
// Ports:
//   isBranch_i, branch_taken_i, predict_taken_i : conditional branch outcome vs prediction
//   isJIRL_i, target_i, target_pred_i            : JIRL actual and predicted targets
//   pc_i                                         : head PC
//   isExcp_i, isErtn_i, isIdle_i                 : head event flags
//   eentry_i, era_i                              : CSR entry / return addresses
//   cause_o                                      : highest-priority cause (C_NONE if none)
//   next_pc_o                                    : redirect address for cause_o
module recovery_pc_sel
    import recovery_pkg::*;
(
    input  logic        isBranch_i,
    input  logic        branch_taken_i,
    input  logic        predict_taken_i,
    input  logic        isJIRL_i,
    input  logic [31:0] target_i,
    input  logic [31:0] target_pred_i,
    input  logic [31:0] pc_i,
    input  logic        isExcp_i,
    input  logic        isErtn_i,
    input  logic        isIdle_i,
    input  logic [31:0] eentry_i,
    input  logic [31:0] era_i,
    output rec_cause_t  cause_o,
    output logic [31:0] next_pc_o
);

    logic mis;

    assign mis = (isBranch_i & (branch_taken_i ^ predict_taken_i))
               | (isJIRL_i & (target_i != target_pred_i));

    // Priority chain; a not-taken branch resumes at the fall-through PC (wraps at 2^32).
    always_comb begin
        cause_o   = C_NONE;
        next_pc_o = '0;
        if (isExcp_i) begin
            cause_o   = C_EXCP;
            next_pc_o = eentry_i;
        end else if (isErtn_i) begin
            cause_o   = C_ERTN;
            next_pc_o = era_i;
        end else if (mis) begin
            cause_o   = C_BR;
            next_pc_o = (branch_taken_i | isJIRL_i) ? target_i : 32'(pc_i + PC_STEP);
        end else if (isIdle_i) begin
            cause_o   = C_IDLE;
            next_pc_o = eentry_i;
        end
    end

endmodule

// File: rtl/recovery_ctrl.sv
// Pipeline recovery sequencer: on a redirecting commit it emits one flush/restore/
// redirect pulse, stalls the front end for RESTORE_CYCLES, or parks in idle-wait
// until an interrupt arrives.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall_in          : global stall, commit outputs invalid while high
//   ready_rob0 ..     : ROB head commit information
//   eentry_csr,era_csr: CSR redirect targets
//   int_pending       : interrupt pending and enabled
//   flush_rob, restore_rat, redirect_valid : one-cycle recovery pulses
//   redirect_pc       : address latched at the redirecting event
//   stall_front, busy : high while not in RUN
//   int_take          : pulse in the idle-wait cycle that sees int_pending
module recovery_ctrl
    import recovery_pkg::*;
#(
    parameter int unsigned RESTORE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        ready_rob0,
    input  logic        isBranch_rob,
    input  logic        Branch_rob,
    input  logic        Predict_rob,
    input  logic        isJIRL_rob,
    input  logic [31:0] target_rob,
    input  logic [31:0] target_pred_rob,
    input  logic [31:0] pc_rob,
    input  logic        isExcp_rob,
    input  logic        isErtn_rob,
    input  logic        isIdle_rob,
    input  logic [31:0] eentry_csr,
    input  logic [31:0] era_csr,
    input  logic        int_pending,
    output logic        flush_rob,
    output logic        restore_rat,
    output logic        stall_front,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        int_take,
    output logic        busy
);

    localparam int unsigned CNT_W = (RESTORE_CYCLES < 1) ? 1 : $clog2(RESTORE_CYCLES + 1);

    rec_state_t         state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               flush_q, flush_d;
    logic               stall_q, stall_d;

    rec_cause_t         sel_cause;
    logic [31:0]        sel_pc;
    logic               ev;

    recovery_pc_sel u_pc_sel (
        .isBranch_i      (isBranch_rob),
        .branch_taken_i  (Branch_rob),
        .predict_taken_i (Predict_rob),
        .isJIRL_i        (isJIRL_rob),
        .target_i        (target_rob),
        .target_pred_i   (target_pred_rob),
        .pc_i            (pc_rob),
        .isExcp_i        (isExcp_rob),
        .isErtn_i        (isErtn_rob),
        .isIdle_i        (isIdle_rob),
        .eentry_i        (eentry_csr),
        .era_i           (era_csr),
        .cause_o         (sel_cause),
        .next_pc_o       (sel_pc)
    );

    // Commits only count in RUN; anything else the ROB presents is being flushed.
    assign ev = ready_rob0 & ~stall_in & (state_q == RUN);

    // Next state; registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            RUN: begin
                if (ev && (sel_cause != C_NONE)) begin
                    redirect_pc_d = sel_pc;
                    state_d       = (sel_cause == C_IDLE) ? IDLE_WAIT : FLUSH;
                end
            end
            FLUSH: begin
                counter_d = CNT_W'(RESTORE_CYCLES);
                state_d   = RESTORE;
            end
            RESTORE: begin
                counter_d = counter_q - CNT_W'(1);
                if (counter_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            IDLE_WAIT: begin
                if (int_pending) begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        flush_d = (state_d == FLUSH);
        stall_d = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            counter_q     <= '0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            stall_q       <= stall_d;
        end
    end

    assign flush_rob      = flush_q;
    assign restore_rat    = flush_q;
    assign redirect_valid = flush_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall_front    = stall_q;
    assign busy           = stall_q;

    // The CSR must see the wake in the same cycle the interrupt is observed, one cycle
    // ahead of the flush; it is the registered state gated by int_pending, masked by reset.
    assign int_take = (state_q == IDLE_WAIT) & int_pending & ~rst;

endmodule

// File: tb/tb_recovery_ctrl.sv
// Directed, table-driven bench for recovery_ctrl. Each vector gives the inputs of one
// cycle, the int_take expected in that cycle, and the registered outputs expected in
// the following cycle.
module tb_recovery_ctrl;

    localparam logic [31:0] EENTRY = 32'h1C008000;
    localparam logic [31:0] ERA    = 32'h1C000040;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        ready_rob0;
    logic        isBranch_rob;
    logic        Branch_rob;
    logic        Predict_rob;
    logic        isJIRL_rob;
    logic [31:0] target_rob;
    logic [31:0] target_pred_rob;
    logic [31:0] pc_rob;
    logic        isExcp_rob;
    logic        isErtn_rob;
    logic        isIdle_rob;
    logic [31:0] eentry_csr;
    logic [31:0] era_csr;
    logic        int_pending;
    logic        flush_rob;
    logic        restore_rat;
    logic        stall_front;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        int_take;
    logic        busy;

    recovery_ctrl #(.RESTORE_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_in        (stall_in),
        .ready_rob0      (ready_rob0),
        .isBranch_rob    (isBranch_rob),
        .Branch_rob      (Branch_rob),
        .Predict_rob     (Predict_rob),
        .isJIRL_rob      (isJIRL_rob),
        .target_rob      (target_rob),
        .target_pred_rob (target_pred_rob),
        .pc_rob          (pc_rob),
        .isExcp_rob      (isExcp_rob),
        .isErtn_rob      (isErtn_rob),
        .isIdle_rob      (isIdle_rob),
        .eentry_csr      (eentry_csr),
        .era_csr         (era_csr),
        .int_pending     (int_pending),
        .flush_rob       (flush_rob),
        .restore_rat     (restore_rat),
        .stall_front     (stall_front),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .int_take        (int_take),
        .busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rdy;
        logic        isbr;
        logic        br;
        logic        pred;
        logic        isj;
        logic [31:0] tgt;
        logic [31:0] tpred;
        logic [31:0] pc;
        logic        excp;
        logic        ertn;
        logic        idle;
        logic        intp;
        logic        e_fl;
        logic        e_st;
        logic        e_tk;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];
    int   n_cmp;
    int   n_bad;

    function automatic vec_t nop();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic vec_t brv(logic taken, logic pred, logic [31:0] tgt, logic [31:0] pc);
        vec_t v;
        v = nop();
        v.rdy  = 1'b1;
        v.isbr = 1'b1;
        v.br   = taken;
        v.pred = pred;
        v.tgt  = tgt;
        v.pc   = pc;
        return v;
    endfunction

    function automatic vec_t jv(logic [31:0] tgt, logic [31:0] tpred, logic [31:0] pc);
        vec_t v;
        v = nop();
        v.rdy   = 1'b1;
        v.isj   = 1'b1;
        v.tgt   = tgt;
        v.tpred = tpred;
        v.pc    = pc;
        return v;
    endfunction

    task automatic add(input vec_t v, input logic fl, input logic st, input logic tk,
                       input logic [31:0] epc);
        vec_t w;
        w      = v;
        w.e_fl = fl;
        w.e_st = st;
        w.e_tk = tk;
        w.e_pc = epc;
        vq.push_back(w);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        rst             = v.rst;
        stall_in        = v.stall;
        ready_rob0      = v.rdy;
        isBranch_rob    = v.isbr;
        Branch_rob      = v.br;
        Predict_rob     = v.pred;
        isJIRL_rob      = v.isj;
        target_rob      = v.tgt;
        target_pred_rob = v.tpred;
        pc_rob          = v.pc;
        isExcp_rob      = v.excp;
        isErtn_rob      = v.ertn;
        isIdle_rob      = v.idle;
        int_pending     = v.intp;
        eentry_csr      = EENTRY;
        era_csr         = ERA;
        #2;
        chk("int_take", idx, 32'(int_take), 32'(v.e_tk));
        @(posedge clk);
        #1;
        chk("flush_rob", idx, 32'(flush_rob), 32'(v.e_fl));
        chk("restore_rat", idx, 32'(restore_rat), 32'(v.e_fl));
        chk("redirect_valid", idx, 32'(redirect_valid), 32'(v.e_fl));
        chk("stall_front", idx, 32'(stall_front), 32'(v.e_st));
        chk("busy", idx, 32'(busy), 32'(v.e_st));
        chk("redirect_pc", idx, redirect_pc, v.e_pc);
    endtask

    initial begin
        vec_t v;
        n_cmp = 0;
        n_bad = 0;

        // reset state
        v = nop(); v.rst = 1'b1;
        add(v, 0, 0, 0, 32'h0);
        add(nop(), 0, 0, 0, 32'h0);

        // taken mispredict: flush next cycle, stall for three cycles
        add(brv(1, 0, 32'h1C000100, 32'h1C000000), 1, 1, 0, 32'h1C000100);
        add(nop(), 0, 1, 0, 32'h1C000100);
        add(nop(), 0, 1, 0, 32'h1C000100);
        add(nop(), 0, 0, 0, 32'h1C000100);
        // correctly predicted branch is not a redirect
        add(brv(1, 1, 32'h1C000900, 32'h1C000010), 0, 0, 0, 32'h1C000100);

        // not-taken mispredict at the top of the address space wraps to 0
        add(brv(0, 1, 32'h12345678, 32'hFFFFFFFC), 1, 1, 0, 32'h0);
        add(nop(), 0, 1, 0, 32'h0);
        add(nop(), 0, 1, 0, 32'h0);
        add(nop(), 0, 0, 0, 32'h0);

        // exception beats ertn and mispredict; events during FLUSH/RESTORE are ignored
        v = brv(1, 0, 32'h1C000100, 32'h1C000020); v.excp = 1'b1; v.ertn = 1'b1;
        add(v, 1, 1, 0, EENTRY);
        v = nop(); v.rdy = 1'b1; v.ertn = 1'b1;
        add(v, 0, 1, 0, EENTRY);
        add(jv(32'h1C000700, 32'h1C000000, 32'h1C000030), 0, 1, 0, EENTRY);
        v = nop(); v.rdy = 1'b1; v.excp = 1'b1;
        add(v, 0, 0, 0, EENTRY);

        // ertn beats a mispredict; accepted on the first RUN cycle
        v = brv(1, 0, 32'h1C000ABC, 32'h1C000044); v.ertn = 1'b1;
        add(v, 1, 1, 0, ERA);
        add(nop(), 0, 1, 0, ERA);
        add(nop(), 0, 1, 0, ERA);
        add(nop(), 0, 0, 0, ERA);

        // JIRL target mispredict, then a JIRL with correct target
        add(jv(32'h1C000200, 32'h1C000300, 32'h1C000050), 1, 1, 0, 32'h1C000200);
        add(nop(), 0, 1, 0, 32'h1C000200);
        add(nop(), 0, 1, 0, 32'h1C000200);
        add(nop(), 0, 0, 0, 32'h1C000200);
        add(jv(32'h1C000204, 32'h1C000204, 32'h1C000060), 0, 0, 0, 32'h1C000200);

        // idle at T, interrupt at T+5: int_take T+5, flush T+6, stall through T+8
        v = nop(); v.rdy = 1'b1; v.idle = 1'b1; v.pc = 32'h1C000070;
        add(v, 0, 1, 0, EENTRY);
        add(nop(), 0, 1, 0, EENTRY);
        v = nop(); v.rdy = 1'b1; v.excp = 1'b1;
        add(v, 0, 1, 0, EENTRY);
        add(nop(), 0, 1, 0, EENTRY);
        add(nop(), 0, 1, 0, EENTRY);
        v = nop(); v.intp = 1'b1;
        add(v, 1, 1, 1, EENTRY);
        add(nop(), 0, 1, 0, EENTRY);
        add(nop(), 0, 1, 0, EENTRY);
        add(nop(), 0, 0, 0, EENTRY);

        // interrupt already pending when idle commits: wake on the first idle-wait cycle
        v = nop(); v.rdy = 1'b1; v.idle = 1'b1; v.intp = 1'b1;
        add(v, 0, 1, 0, EENTRY);
        v = nop(); v.intp = 1'b1;
        add(v, 1, 1, 1, EENTRY);
        add(nop(), 0, 1, 0, EENTRY);
        add(nop(), 0, 1, 0, EENTRY);
        add(nop(), 0, 0, 0, EENTRY);

        // reset during RESTORE, then a stalled commit does nothing
        add(brv(1, 0, 32'h1C000500, 32'h1C000080), 1, 1, 0, 32'h1C000500);
        add(nop(), 0, 1, 0, 32'h1C000500);
        v = nop(); v.rst = 1'b1;
        add(v, 0, 0, 0, 32'h0);
        add(nop(), 0, 0, 0, 32'h0);
        v = nop(); v.rdy = 1'b1; v.stall = 1'b1; v.excp = 1'b1;
        add(v, 0, 0, 0, 32'h0);
        add(nop(), 0, 0, 0, 32'h0);

        // stall_in during FLUSH/RESTORE does not stretch the window
        add(brv(1, 0, 32'h1C000600, 32'h1C000090), 1, 1, 0, 32'h1C000600);
        v = nop(); v.stall = 1'b1;
        add(v, 0, 1, 0, 32'h1C000600);
        add(v, 0, 1, 0, 32'h1C000600);
        add(nop(), 0, 0, 0, 32'h1C000600);

        // reset while parked with an interrupt pending: no wake, no flush
        v = nop(); v.rdy = 1'b1; v.idle = 1'b1;
        add(v, 0, 1, 0, EENTRY);
        v = nop(); v.rst = 1'b1; v.intp = 1'b1;
        add(v, 0, 0, 0, 32'h0);
        v = nop(); v.intp = 1'b1;
        add(v, 0, 0, 0, 32'h0);

        foreach (vq[i]) begin
            run_vec(vq[i], i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
